// File: rtl/mic_frame_reader_if.sv
// rtl/mic_frame_reader_if.sv - sample stream bundle between frame reader and beamformer
interface mic_frame_reader_if #(
    parameter int DATA_W = 16
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/mic_frame_reader.sv
// rtl/mic_frame_reader.sv - reads one delayed 2^ADDR_W-sample frame from RAM into a stream; optional ENERGY_ACC_EN adds energy port
module mic_frame_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] delay,
    output logic              busy,
    output logic              done,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_dout,
    mic_frame_reader_if.master m
`ifdef ENERGY_ACC_EN
    ,
    output logic [39:0]       energy
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] delay_q;
    logic [ADDR_W-1:0] k;
    logic              rd_pend;
    logic              rd_last;
    logic [DATA_W-1:0] buf_data [2];
    logic              buf_last [2];
    logic [1:0]        count;

    logic has_buf;
    logic issue;
    logic pop;
    logic pop_buf;
    logic push;
    logic last_beat;
    logic push_to_head;

    // Read issue, RAM address and stream outputs; the in-flight read is presented
    // directly when the buffer is empty so the first beat costs no extra cycle.
    always_comb begin
        has_buf      = (count != 2'd0);
        issue        = (state == S_RUN) && ((count == 2'd0) || ((count == 2'd1) && !rd_pend));
        ram_ceb      = issue;
        ram_adb      = (state == S_RUN) ? (delay_q + k) : '0;
        busy         = (state != S_IDLE);
        m.m_valid    = has_buf || rd_pend;
        m.m_data     = has_buf ? buf_data[0] : (rd_pend ? ram_dout : '0);
        m.m_last     = has_buf ? buf_last[0] : (rd_pend && rd_last);
        pop          = m.m_valid && m.m_ready;
        pop_buf      = pop && has_buf;
        push         = rd_pend && !(pop && !has_buf);
        last_beat    = pop && m.m_last;
        push_to_head = (count == 2'd0) || ((count == 2'd1) && pop_buf);
    end

    // Frame sequencing: accept start only when idle, walk k across the whole RAM once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            delay_q <= '0;
            k       <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_beat;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        delay_q <= delay;
                        k       <= '0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        k <= k + 1'b1;
                        if (k == '1) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_beat) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Track the read whose data returns next cycle, tagging the final address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            rd_pend <= issue;
            rd_last <= issue && (k == '1);
        end
    end

    // Two-entry output buffer holding returned samples while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (pop_buf) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
            end
            if (push) begin
                if (push_to_head) begin
                    buf_data[0] <= ram_dout;
                    buf_last[0] <= rd_last;
                end else begin
                    buf_data[1] <= ram_dout;
                    buf_last[1] <= rd_last;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop_buf};
        end
    end

`ifdef ENERGY_ACC_EN
    logic signed [2*DATA_W-1:0] sq;

    // Signed square of the beat currently on the stream.
    always_comb begin
        sq = $signed(m.m_data) * $signed(m.m_data);
    end

    // Energy sum restarts with each accepted frame and grows on every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            energy <= '0;
        end else if ((state == S_IDLE) && start) begin
            energy <= '0;
        end else if (pop) begin
            energy <= energy + {{(40-2*DATA_W){1'b0}}, sq};
        end
    end
`endif

endmodule

// File: tb/tb_mic_frame_reader.sv
// tb/tb_mic_frame_reader.sv - directed self-checking bench for mic_frame_reader
module tb_mic_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  delay = '0;
    logic        busy;
    logic        done;
    logic        ram_ceb;
    logic [8:0]  ram_adb;
    logic [15:0] ram_dout = '0;
    logic        ready_drv = 1'b0;
`ifdef ENERGY_ACC_EN
    logic [39:0] energy;
    logic [39:0] energy_at_done;
`endif

    logic [15:0] mem [0:511];

    mic_frame_reader_if #(.DATA_W(16)) sif ();
    assign sif.m_ready = ready_drv;

    mic_frame_reader #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .delay    (delay),
        .busy     (busy),
        .done     (done),
        .ram_ceb  (ram_ceb),
        .ram_adb  (ram_adb),
        .ram_dout (ram_dout),
        .m        (sif)
`ifdef ENERGY_ACC_EN
        ,
        .energy   (energy)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ceb) ram_dout <= mem[ram_adb];
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] bdata [0:1023];
    logic        blast [0:1023];
    int          bcyc  [0:1023];
    int          nbeats;
    int          done_cyc;
    int          done_pulses;
    int          stab_err;
    int          last_flags;
    logic        busy_c1;
    logic        busy_at_done;

    task automatic init_image();
        for (int a = 0; a < 512; a++) mem[a] = 16'((a * 97) ^ 16'h2A5C);
        mem[0]   = 16'hFFFB;
        mem[1]   = 16'hFF46;
        mem[2]   = 16'hFFA6;
        mem[509] = 16'hFC52;
        mem[510] = 16'h0000;
        mem[511] = 16'h0000;
    endtask

    task automatic fill_image(input logic [15:0] v);
        for (int a = 0; a < 512; a++) mem[a] = v;
    endtask

    // mode 0: always ready; mode 1: alternate ready plus a random stall window
    task automatic run_frame(input logic [8:0] d, input int mode, input int inj_beat, input int stop_beats);
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        int          stall_at;
        int          stall_len;
        nbeats = 0; done_cyc = -1; done_pulses = 0; stab_err = 0; last_flags = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        busy_c1 = 1'b0; busy_at_done = 1'b1;
        stall_at  = int'($urandom_range(100, 300));
        stall_len = int'($urandom_range(3, 9));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            if (cyc == 0) delay = d;
            if (mode == 0) ready_drv = 1'b1;
            else ready_drv = (cyc % 2 == 0) && !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (cyc == 1) busy_c1 = busy;
            if (prev_stall && (!sif.m_valid || sif.m_data !== prev_data || sif.m_last !== prev_last)) stab_err++;
            prev_stall = sif.m_valid && !ready_drv;
            prev_data  = sif.m_data;
            prev_last  = sif.m_last;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
`ifdef ENERGY_ACC_EN
                    energy_at_done = energy;
`endif
                end
            end
            if (sif.m_valid && ready_drv && nbeats < 1024) begin
                bdata[nbeats] = sif.m_data;
                blast[nbeats] = sif.m_last;
                bcyc[nbeats]  = cyc;
                if (sif.m_last) last_flags++;
                nbeats++;
                if (inj_beat > 0 && nbeats == inj_beat) begin
                    start = 1'b1;
                    delay = 9'd7;
                end
            end
            if (stop_beats > 0 && nbeats >= stop_beats) return;
            if (done_cyc >= 0 && cyc == done_cyc + 1) return;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ram_ceb !== 1'b0) begin errors++; $display("FAIL reset_ram_ceb: got %b expected 0", ram_ceb); end
        checks++; if (ram_adb !== 9'd0) begin errors++; $display("FAIL reset_ram_adb: got %h expected 000", ram_adb); end
        checks++; if (sif.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", sif.m_valid); end
        checks++; if (sif.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", sif.m_last); end
        checks++; if (sif.m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h expected 0000", sif.m_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_delay0();
        int bad;
        run_frame(9'd0, 0, -1, 0);
        bad = 0;
        for (int i = 0; i < nbeats && i < 512; i++) if (bdata[i] !== mem[i]) bad++;
        checks++; if (nbeats !== 512) begin errors++; $display("FAIL d0_beats: got %0d expected 512", nbeats); end
        checks++; if (bcyc[0] !== 2) begin errors++; $display("FAIL d0_first_latency: got %0d expected 2", bcyc[0]); end
        checks++; if (bdata[0] !== 16'hFFFB) begin errors++; $display("FAIL d0_beat1: got %h expected fffb", bdata[0]); end
        checks++; if (bdata[1] !== 16'hFF46) begin errors++; $display("FAIL d0_beat2: got %h expected ff46", bdata[1]); end
        checks++; if (bdata[2] !== 16'hFFA6) begin errors++; $display("FAIL d0_beat3: got %h expected ffa6", bdata[2]); end
        checks++; if (bdata[511] !== 16'h0000 || blast[511] !== 1'b1) begin errors++; $display("FAIL d0_last_beat: got %h/%b expected 0000/1", bdata[511], blast[511]); end
        checks++; if (last_flags !== 1) begin errors++; $display("FAIL d0_last_count: got %0d expected 1", last_flags); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL d0_order: got %0d wrong beats expected 0", bad); end
        checks++; if (bcyc[511] !== 513) begin errors++; $display("FAIL d0_no_bubbles: got last beat cycle %0d expected 513", bcyc[511]); end
        checks++; if (done_cyc !== 514) begin errors++; $display("FAIL d0_done_cycle: got %0d expected 514", done_cyc); end
        checks++; if (done_pulses !== 1) begin errors++; $display("FAIL d0_done_width: got %0d expected 1", done_pulses); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL d0_busy_at_done: got %b expected 0", busy_at_done); end
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL d0_busy_after_start: got %b expected 1", busy_c1); end
    endtask

    task automatic test_wrap();
        int bad;
        run_frame(9'd510, 0, -1, 0);
        bad = 0;
        for (int i = 0; i < nbeats && i < 512; i++) if (bdata[i] !== mem[(510 + i) % 512]) bad++;
        checks++; if (nbeats !== 512) begin errors++; $display("FAIL wrap_beats: got %0d expected 512", nbeats); end
        checks++; if (bdata[0] !== 16'h0000) begin errors++; $display("FAIL wrap_beat1: got %h expected 0000", bdata[0]); end
        checks++; if (bdata[1] !== 16'h0000) begin errors++; $display("FAIL wrap_beat2: got %h expected 0000", bdata[1]); end
        checks++; if (bdata[2] !== 16'hFFFB) begin errors++; $display("FAIL wrap_beat3: got %h expected fffb", bdata[2]); end
        checks++; if (bdata[511] !== 16'hFC52 || blast[511] !== 1'b1) begin errors++; $display("FAIL wrap_last: got %h/%b expected fc52/1", bdata[511], blast[511]); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_order: got %0d wrong beats expected 0", bad); end
    endtask

    task automatic test_stall();
        int bad;
        run_frame(9'd0, 1, -1, 0);
        bad = 0;
        for (int i = 0; i < nbeats && i < 512; i++) if (bdata[i] !== mem[i]) bad++;
        checks++; if (nbeats !== 512) begin errors++; $display("FAIL stall_beats: got %0d expected 512", nbeats); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order: got %0d wrong beats expected 0", bad); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stability: got %0d unstable cycles expected 0", stab_err); end
        checks++; if (last_flags !== 1 || blast[511] !== 1'b1) begin errors++; $display("FAIL stall_last: got %0d flags/%b expected 1/1", last_flags, blast[511]); end
        checks++; if (done_pulses !== 1) begin errors++; $display("FAIL stall_done: got %0d pulses expected 1", done_pulses); end
    endtask

    task automatic test_start_ignored();
        int bad;
        run_frame(9'd0, 0, 50, 0);
        bad = 0;
        for (int i = 0; i < nbeats && i < 512; i++) if (bdata[i] !== mem[i]) bad++;
        checks++; if (nbeats !== 512) begin errors++; $display("FAIL ign_beats: got %0d expected 512", nbeats); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ign_order: got %0d wrong beats expected 0", bad); end
        checks++; if (done_cyc !== 514) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 514", done_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(9'd0, 0, -1, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, ram_ceb, sif.m_valid, sif.m_last} !== 5'b0) begin errors++; $display("FAIL mid_rst_flags: got %b expected 00000", {busy, done, ram_ceb, sif.m_valid, sif.m_last}); end
        checks++; if (ram_adb !== 9'd0 || sif.m_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_buses: got %h/%h expected 000/0000", ram_adb, sif.m_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(9'd0, 0, -1, 0);
        checks++; if (bdata[0] !== 16'hFFFB) begin errors++; $display("FAIL mid_rst_first: got %h expected fffb", bdata[0]); end
        checks++; if (nbeats !== 512 || bcyc[0] !== 2) begin errors++; $display("FAIL mid_rst_frame: got %0d beats first at %0d expected 512 at 2", nbeats, bcyc[0]); end
    endtask

`ifdef ENERGY_ACC_EN
    task automatic test_energy();
        fill_image(16'h8000);
        run_frame(9'd0, 0, -1, 0);
        checks++; if (energy_at_done !== 40'h80_0000_0000) begin errors++; $display("FAIL energy_8000: got %h expected 8000000000", energy_at_done); end
        fill_image(16'h0003);
        run_frame(9'd0, 1, -1, 0);
        checks++; if (energy_at_done !== 40'h00_0000_1200) begin errors++; $display("FAIL energy_0003: got %h expected 0000001200", energy_at_done); end
        init_image();
    endtask
`endif

    initial begin
        init_image();
        test_reset();
        test_delay0();
        test_wrap();
        test_stall();
        test_start_ignored();
        test_reset_mid_frame();
`ifdef ENERGY_ACC_EN
        test_energy();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_frame_reader.md
MIC_FRAME_READER -- requirements
Module: mic_frame_reader

Interface
REQ-001 SHALL have parameters: ADDR_W, default 9, sample RAM address width; DATA_W, default 16, signed sample width.
REQ-002 SHALL have port clk, input, 1, sole clock; it also clocks the read port of the sample RAM.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle frame request.
REQ-005 SHALL have port delay, input, ADDR_W, beamforming start offset, sampled on accepted start.
REQ-006 SHALL have ports busy (output, 1, frame in progress) and done (output, 1, one-cycle end-of-frame pulse).
REQ-007 SHALL have ports ram_ceb (output, 1, read enable) and ram_adb (output, ADDR_W, read address) to the sample RAM read port.
REQ-008 SHALL have port ram_dout, input, DATA_W, RAM read data, valid one cycle after the ram_ceb cycle (bypass read mode).
REQ-009 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_W) and m_last (output, 1), forming the sample stream to the beamformer.

Function
REQ-010 SHALL implement states IDLE, RUN and DRAIN.
REQ-011 IDLE->RUN SHALL occur on start=1; delay is latched, the read counter k is cleared and busy=1 from the next cycle.
REQ-012 start SHALL be ignored in RUN and DRAIN; delay changes after acceptance SHALL have no effect on the current frame.
REQ-013 In RUN, read k SHALL drive ram_adb=(delay+k) mod 2^ADDR_W for k=0..2^ADDR_W-1, with wrap from 511 to 0.
REQ-014 ram_ceb SHALL assert only when the 2-entry output buffer has a free slot counting the in-flight read; no sample SHALL be lost or duplicated.
REQ-015 RUN->DRAIN SHALL occur after the read with k=2^ADDR_W-1 is issued; DRAIN->IDLE SHALL occur on the handshake of the last beat.
REQ-016 A beat SHALL transfer on m_valid&m_ready; m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-017 m_last SHALL be 1 only on the 512th beat of the frame.
REQ-018 done SHALL pulse exactly one cycle after the last-beat handshake; busy SHALL drop in the same cycle.
REQ-019 With m_ready held at 1, the first beat SHALL appear 2 cycles after start, at 1 beat/cycle, with no bubbles.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE and set busy, done, ram_ceb, m_valid and m_last to 0, and ram_adb, m_data and all counters to 0, including mid-frame.
REQ-021 After reset release, the next start SHALL begin a full frame from k=0; no partial frame SHALL be resumed.

Configuration
REQ-022 With ENERGY_ACC_EN defined, output port energy [39:0] SHALL exist; it clears on accepted start, accumulates m_data*m_data (signed square, unsigned sum) on each handshake, and is final when done pulses.
REQ-023 Without ENERGY_ACC_EN, the energy port and its multiplier SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Preloaded channel-5 image, delay=0, m_ready=1: beats are 0xFFFB, 0xFF46, 0xFFA6, and so on; the 512th beat is 0x0000 with m_last=1; done pulses on the next cycle.
REQ-025 delay=510: beats 1-3 are 0x0000 (addr 510), 0x0000 (addr 511) and 0xFFFB (addr 0, wrap); the last beat is 0xFC52 (addr 509).
REQ-026 m_ready pattern 1,0,1,0,... plus a random stall: exactly 512 beats, in order, and m_data is stable during every stall.
REQ-027 start pulsed with delay=7 at beat 50 of a delay=0 frame: it is ignored, and the frame completes unchanged.
REQ-028 rst_n low at beat 100: all outputs are 0 during reset; after release, start with delay=0 yields first beat 0xFFFB.
REQ-029 ENERGY_ACC_EN, RAM filled with 0x8000: at done, energy=0x80_0000_0000; RAM filled with 0x0003: energy=0x00_0000_1200.
